// File: rtl/cpu_pkg.sv
// Shared types for the multicycle CPU controller:
// FSM states, opcodes and ALU operation codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_ADDI = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BLT  = 4'hB,
    OP_BVS  = 4'hC,
    OP_JMP  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;

  // Register ops pass straight through; memory and branch ops reuse ADD/SUB.
  function automatic logic [3:0] alu_sel(input opcode_t op);
    logic [3:0] r;
    unique case (1'b1)
      (op <= OP_SRL):                       r = op;
      (op inside {OP_ADDI, OP_LW, OP_SW}):  r = ALU_ADD;
      (op inside {OP_BEQ, OP_BLT, OP_BVS}): r = ALU_SUB;
      default:                              r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// Wait-state counter shared by the fetch and data handshakes;
// expired flags that the limit has been reached.
module cpu_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(WAIT_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_mc_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, bus timeout, HALT and single-step.
module cpu_mc_ctrl
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter bit STEP_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Overflow,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_load,
  output logic       pc_load,
  output logic       branch,
  output logic       jump,
  output logic       rf_write_en,
  output logic       rf_mux_sel,
  output logic       alu_mux_sel,
  output logic       data_out_mux,
  output logic [3:0] alu_opcode,
  output logic       halted,
  output logic       bus_err,
  input  logic       step_mode,
  input  logic       step,
  output logic [2:0] state_dbg
);

  state_t  state, state_n;
  opcode_t op_q;
  logic    step_armed;
  logic    fetch_req, fetch_ld;
  logic    mem_req, mem_done;
  logic    t_clear, t_inc, expired;

  assign fetch_req = (state == S_FETCH)
                   && !(STEP_EN && step_mode && !step_armed);
  assign fetch_ld  = fetch_req && imem_ack;
  assign mem_req   = (state == S_MEM);
  assign mem_done  = mem_req && dmem_ack;

  // Counter idles at zero outside the two handshake states.
  assign t_clear = !(state inside {S_FETCH, S_MEM})
                 || fetch_ld || mem_done;
  assign t_inc   = (fetch_req && !imem_ack)
                 || (mem_req && !dmem_ack);

  cpu_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (t_clear),
    .inc    (t_inc),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_FETCH;
      op_q       <= OP_ADD;
      step_armed <= 1'b0;
    end else begin
      state <= state_n;
      if (fetch_ld) begin
        op_q       <= opcode_t'(opcode);
        step_armed <= 1'b0;
      end else if (STEP_EN && step && step_mode) begin
        step_armed <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    pc_load      = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    rf_write_en  = 1'b0;
    rf_mux_sel   = 1'b0;
    alu_mux_sel  = 1'b0;
    data_out_mux = 1'b0;
    halted       = 1'b0;
    bus_err      = 1'b0;
    alu_opcode   = alu_sel(op_q);
    state_dbg    = state;

    unique case (state)
      S_FETCH: begin
        imem_req = fetch_req;
        ir_load  = fetch_ld;
        if (fetch_ld) begin
          state_n = S_DECODE;
        end else if (fetch_req && expired) begin
          state_n = S_ERR;
        end
      end
      S_DECODE: state_n = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          (op_q inside {OP_LW, OP_SW}): state_n = S_MEM;
          (op_q inside {OP_BEQ, OP_BLT, OP_BVS}): begin
            pc_load = 1'b1;
            branch  = (op_q == OP_BEQ) ? Zero
                    : (op_q == OP_BLT) ? Negative
                    : Overflow;
            state_n = S_FETCH;
          end
          (op_q == OP_JMP): begin
            pc_load = 1'b1;
            jump    = 1'b1;
            state_n = S_FETCH;
          end
          (op_q == OP_NOP): begin
            pc_load = 1'b1;
            state_n = S_FETCH;
          end
          (op_q == OP_HALT): state_n = S_HALT;
          default: begin
            alu_mux_sel = (op_q == OP_ADDI);
            state_n     = S_WB;
          end
        endcase
      end
      S_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = (op_q == OP_SW);
        alu_mux_sel = 1'b1;
        if (dmem_ack) begin
          if (op_q == OP_SW) begin
            pc_load = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (expired) begin
          state_n = S_ERR;
        end
      end
      S_WB: begin
        rf_write_en  = 1'b1;
        data_out_mux = (op_q == OP_LW);
        rf_mux_sel   = (op_q inside {OP_ADDI, OP_LW});
        alu_mux_sel  = (op_q == OP_ADDI);
        pc_load      = 1'b1;
        state_n      = S_FETCH;
      end
      S_HALT:  halted  = 1'b1;
      S_ERR:   bus_err = 1'b1;
      default: state_n = S_FETCH;
    endcase

    // Everything stays quiet while reset is held low.
    if (!reset) begin
      imem_req     = 1'b0;
      ir_load      = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      pc_load      = 1'b0;
      branch       = 1'b0;
      jump         = 1'b0;
      rf_write_en  = 1'b0;
      rf_mux_sel   = 1'b0;
      alu_mux_sel  = 1'b0;
      data_out_mux = 1'b0;
      halted       = 1'b0;
      bus_err      = 1'b0;
      alu_opcode   = 4'd0;
      state_dbg    = 3'd0;
    end
  end

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Scoreboard bench for cpu_mc_ctrl: stimulus queues the expected
// control word per cycle, a negedge monitor pops and compares.
module tb_cpu_mc_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  alu;
    logic [12:0] f;
  } ctl_t;

  typedef struct {
    ctl_t  v;
    string tag;
  } item_t;

  localparam logic [12:0] IREQ = 13'h1000;
  localparam logic [12:0] IRL  = 13'h0800;
  localparam logic [12:0] DREQ = 13'h0400;
  localparam logic [12:0] DWE  = 13'h0200;
  localparam logic [12:0] PCL  = 13'h0100;
  localparam logic [12:0] BR   = 13'h0080;
  localparam logic [12:0] JMP  = 13'h0040;
  localparam logic [12:0] RFW  = 13'h0020;
  localparam logic [12:0] RFM  = 13'h0010;
  localparam logic [12:0] ALM  = 13'h0008;
  localparam logic [12:0] DOM  = 13'h0004;
  localparam logic [12:0] HLT  = 13'h0002;
  localparam logic [12:0] BER  = 13'h0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       Zero, Negative, Overflow;
  logic       imem_req, imem_ack;
  logic       dmem_req, dmem_we, dmem_ack;
  logic       ir_load, pc_load, branch, jump;
  logic       rf_write_en, rf_mux_sel, alu_mux_sel, data_out_mux;
  logic [3:0] alu_opcode;
  logic       halted, bus_err;
  logic       step_mode, step;
  logic [2:0] state_dbg;

  int    checks = 0;
  int    errors = 0;
  item_t exp_q[$];
  item_t cur;
  ctl_t  act;

  always #5 clk = ~clk;

  cpu_mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .pc_load(pc_load),
    .branch(branch), .jump(jump),
    .rf_write_en(rf_write_en), .rf_mux_sel(rf_mux_sel),
    .alu_mux_sel(alu_mux_sel), .data_out_mux(data_out_mux),
    .alu_opcode(alu_opcode), .halted(halted), .bus_err(bus_err),
    .step_mode(step_mode), .step(step), .state_dbg(state_dbg)
  );

  function automatic ctl_t e(input logic [2:0] s,
                             input logic [3:0] a,
                             input logic [12:0] f);
    ctl_t r;
    r.st  = s;
    r.alu = a;
    r.f   = f;
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      act = {state_dbg, alu_opcode,
             imem_req, ir_load, dmem_req, dmem_we, pc_load,
             branch, jump, rf_write_en, rf_mux_sel,
             alu_mux_sel, data_out_mux, halted, bus_err};
      checks++;
      if (act !== cur.v) begin
        errors++;
        $display("FAIL %s @%0t: got st=%0d alu=%h f=%b want st=%0d alu=%h f=%b",
                 cur.tag, $time, act.st, act.alu, act.f,
                 cur.v.st, cur.v.alu, cur.v.f);
      end
    end
  end

  task automatic go(input string tag, input ctl_t v);
    item_t it;
    it.v   = v;
    it.tag = tag;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] opc,
                       input logic [3:0] prev_alu,
                       input int waits);
    imem_ack = 1'b0;
    opcode   = opc;
    for (int i = 0; i < waits; i++) go("fetch_wait", e(0, prev_alu, IREQ));
    imem_ack = 1'b1;
    go("fetch", e(0, prev_alu, IREQ | IRL));
    imem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; opcode = 4'h0;
    Zero = 1'b0; Negative = 1'b0; Overflow = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    step_mode = 1'b0; step = 1'b0;
    @(posedge clk);
    #1;
    go("rst", e(0, 0, 0));
    go("rst", e(0, 0, 0));
    reset = 1'b1;

    fetch(4'h0, 4'h0, 0);
    go("add_dec", e(1, 0, 0));
    go("add_exe", e(2, 0, 0));
    go("add_wb",  e(4, 0, RFW | PCL));

    fetch(4'h8, 4'h0, 0);
    go("lw_dec", e(1, 0, 0));
    go("lw_exe", e(2, 0, 0));
    for (int i = 0; i < 3; i++) go("lw_mem", e(3, 0, DREQ | ALM));
    dmem_ack = 1'b1;
    go("lw_ack", e(3, 0, DREQ | ALM));
    dmem_ack = 1'b0;
    go("lw_wb", e(4, 0, RFW | PCL | RFM | DOM));

    fetch(4'hA, 4'h0, 0);
    go("beq_dec", e(1, 1, 0));
    Zero = 1'b1;
    go("beq_taken", e(2, 1, PCL | BR));
    Zero = 1'b0;
    fetch(4'hA, 4'h1, 0);
    go("beq_dec", e(1, 1, 0));
    go("beq_not", e(2, 1, PCL));
    fetch(4'hC, 4'h1, 0);
    go("bvs_dec", e(1, 1, 0));
    Overflow = 1'b1;
    go("bvs_taken", e(2, 1, PCL | BR));
    fetch(4'hB, 4'h1, 0);
    go("blt_dec", e(1, 1, 0));
    Zero = 1'b1;
    go("blt_not", e(2, 1, PCL));
    Zero = 1'b0; Overflow = 1'b0;

    fetch(4'hD, 4'h1, 0);
    go("jmp_dec", e(1, 0, 0));
    go("jmp_exe", e(2, 0, PCL | JMP));

    fetch(4'h7, 4'h0, 0);
    go("addi_dec", e(1, 0, 0));
    go("addi_exe", e(2, 0, ALM));
    go("addi_wb",  e(4, 0, RFW | PCL | RFM | ALM));

    fetch(4'h9, 4'h0, 0);
    go("sw_dec", e(1, 0, 0));
    go("sw_exe", e(2, 0, 0));
    go("sw_mem", e(3, 0, DREQ | DWE | ALM));
    dmem_ack = 1'b1;
    go("sw_ack", e(3, 0, DREQ | DWE | ALM | PCL));
    dmem_ack = 1'b0;

    fetch(4'h1, 4'h0, 2);
    dmem_ack = 1'b1;
    go("sub_dec", e(1, 1, 0));
    go("sub_exe", e(2, 1, 0));
    dmem_ack = 1'b0;
    go("sub_wb", e(4, 1, RFW | PCL));

    fetch(4'h2, 4'h1, 0);
    go("and_dec", e(1, 2, 0));
    go("and_exe", e(2, 2, 0));
    go("and_wb",  e(4, 2, RFW | PCL));

    fetch(4'hE, 4'h2, 15);
    go("nop_dec", e(1, 0, 0));
    go("nop_exe", e(2, 0, PCL));

    imem_ack = 1'b0;
    for (int i = 0; i < 16; i++) go("to_fetch", e(0, 0, IREQ));
    go("to_err", e(6, 0, BER));
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) go("err_sticky", e(6, 0, BER));
    imem_ack = 1'b0;
    reset = 1'b0;
    go("rst_err", e(0, 0, 0));
    reset = 1'b1;
    go("post_err", e(0, 0, IREQ));

    step_mode = 1'b1;
    imem_ack  = 1'b1;
    opcode    = 4'hE;
    for (int i = 0; i < 10; i++) go("step_idle", e(0, 0, 0));
    step = 1'b1;
    go("step_pulse", e(0, 0, 0));
    step = 1'b0;
    go("step_fetch", e(0, 0, IREQ | IRL));
    go("step_dec", e(1, 0, 0));
    go("step_exe", e(2, 0, PCL));
    for (int i = 0; i < 3; i++) go("step_hold", e(0, 0, 0));
    step_mode = 1'b0;

    fetch(4'hF, 4'h0, 0);
    go("halt_dec", e(1, 0, 0));
    go("halt_exe", e(2, 0, 0));
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < 20; i++) go("halt", e(5, 0, HLT));
    reset = 1'b0;
    go("rst_halt", e(0, 0, 0));
    reset = 1'b1;
    dmem_ack = 1'b0;

    fetch(4'h9, 4'h0, 0);
    go("sw2_dec", e(1, 0, 0));
    go("sw2_exe", e(2, 0, 0));
    go("sw2_mem", e(3, 0, DREQ | DWE | ALM));
    go("sw2_mem", e(3, 0, DREQ | DWE | ALM));
    reset = 1'b0;
    dmem_ack = 1'b1;
    go("rst_mem", e(0, 0, 0));
    reset = 1'b1;
    dmem_ack = 1'b0;
    go("post_mem", e(0, 0, IREQ));

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
